// File: rtl/issue_scoreboard_v2.sv
// rtl/issue_scoreboard_v2.sv - in-order issue scoreboard with per-register latency countdowns
//
// Decides, each cycle, which in-order prefix of an issue bundle may issue.
// Hazards checked: RAW/WAW against in-flight results (per-register countdown),
// RAW/WAW within the bundle, a branch ending its bundle, a post-branch stall
// window, and a synchronous flush.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   issue_valid    per-slot valid
//   rs1, rs2, rd   per-slot register indices
//   rd_valid       per-slot "writes rd"
//   lat            per-slot result latency (0 treated as 1)
//   branch         per-slot control-flow flag
//   flush          kill all tracking state, block issue this cycle
//   can_issue      per-slot issue permission (combinational)
//   busy_mask      per-register "counter nonzero" (from state)
//   branch_stall   branch countdown nonzero (from state)

module issue_scoreboard_v2 #(
    parameter int NUM_WIDTH    = 4,
    parameter int RD_WIDTH     = 5,
    parameter int NUM_REGS     = 32,
    parameter int LAT_WIDTH    = 4,
    parameter int BYPASS       = 1,
    parameter int BRANCH_STALL = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_WIDTH-1:0]                 issue_valid,
    input  logic [NUM_WIDTH-1:0][RD_WIDTH-1:0]   rs1,
    input  logic [NUM_WIDTH-1:0][RD_WIDTH-1:0]   rs2,
    input  logic [NUM_WIDTH-1:0][RD_WIDTH-1:0]   rd,
    input  logic [NUM_WIDTH-1:0]                 rd_valid,
    input  logic [NUM_WIDTH-1:0][LAT_WIDTH-1:0]  lat,
    input  logic [NUM_WIDTH-1:0]                 branch,
    input  logic                                 flush,
    output logic [NUM_WIDTH-1:0]                 can_issue,
    output logic [NUM_REGS-1:0]                  busy_mask,
    output logic                                 branch_stall
);

    // Keep the branch counter at least one bit wide so BRANCH_STALL = 0 still elaborates.
    localparam int BW = (BRANCH_STALL > 0) ? $clog2(BRANCH_STALL + 1) : 1;

    logic [LAT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [LAT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic [BW-1:0]        bcnt_q;
    logic [BW-1:0]        bcnt_d;

    logic [NUM_REGS-1:0]  ready;
    logic [NUM_WIDTH-1:0] hazard;
    logic [NUM_WIDTH-1:0] fire;
    logic                 chain_ok;

    // A register is ready when its result is done, or lands next edge and can be forwarded.
    always_comb begin
        ready = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ready[r] = (cnt_q[r] == '0) ||
                       ((BYPASS != 0) && (cnt_q[r] == LAT_WIDTH'(1)));
        end
        ready[0] = 1'b1;
    end

    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_WIDTH; i++) begin
            if ((rs1[i] != '0) && !ready[rs1[i]]) hazard[i] = 1'b1;
            if ((rs2[i] != '0) && !ready[rs2[i]]) hazard[i] = 1'b1;
            if (rd_valid[i] && (rd[i] != '0) && !ready[rd[i]]) hazard[i] = 1'b1;
            // Earlier producers in the same bundle are never forwarded from.
            for (int j = 0; j < i; j++) begin
                if (issue_valid[j] && rd_valid[j] && (rd[j] != '0) &&
                    ((rd[j] == rs1[i]) || (rd[j] == rs2[i]) || (rd[j] == rd[i])))
                    hazard[i] = 1'b1;
                if (issue_valid[j] && branch[j])
                    hazard[i] = 1'b1;
            end
        end
    end

    // In-order prefix: once a slot is blocked, every later slot is blocked too.
    always_comb begin
        can_issue = '0;
        chain_ok  = (bcnt_q == '0) && !flush;
        for (int i = 0; i < NUM_WIDTH; i++) begin
            chain_ok     = chain_ok && !hazard[i];
            can_issue[i] = chain_ok;
        end
    end

    assign fire = issue_valid & can_issue;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_WIDTH'(1)) : '0;
        end
        cnt_d[0] = '0;
        // A new issue overrides the decrement of the same register.
        for (int i = 0; i < NUM_WIDTH; i++) begin
            if (fire[i] && rd_valid[i] && (rd[i] != '0))
                cnt_d[rd[i]] = (lat[i] == '0) ? LAT_WIDTH'(1) : lat[i];
        end

        if ((fire & branch) != '0)
            bcnt_d = BW'(BRANCH_STALL);
        else if (bcnt_q != '0)
            bcnt_d = bcnt_q - BW'(1);
        else
            bcnt_d = bcnt_q;

        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            bcnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = (cnt_q[r] != '0);
    end

    assign branch_stall = (bcnt_q != '0);

endmodule

// File: tb/tb_issue_scoreboard_v2.sv
// tb/tb_issue_scoreboard_v2.sv - self-checking bench for issue_scoreboard_v2

module tb_issue_scoreboard_v2;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      issue_valid;
    logic [3:0][4:0] rs1, rs2, rd;
    logic [3:0]      rd_valid;
    logic [3:0][3:0] lat;
    logic [3:0]      branch;
    logic            flush;

    logic [3:0]      can_a, can_b;
    logic [31:0]     busy_a, busy_b;
    logic            bs_a, bs_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  can_a;
        logic [3:0]  can_b;
    } can_exp_t;

    typedef struct {
        string       tag;
        logic [31:0] busy_a;
        logic [31:0] busy_b;
        logic        bs;
    } st_exp_t;

    can_exp_t can_q[$];
    st_exp_t  st_q[$];

    always #5 clk = ~clk;

    issue_scoreboard_v2 u_dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
        .rd(rd), .rd_valid(rd_valid), .lat(lat), .branch(branch), .flush(flush),
        .can_issue(can_a), .busy_mask(busy_a), .branch_stall(bs_a)
    );

    issue_scoreboard_v2 #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
        .rd(rd), .rd_valid(rd_valid), .lat(lat), .branch(branch), .flush(flush),
        .can_issue(can_b), .busy_mask(busy_b), .branch_stall(bs_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        issue_valid = '0; rs1 = '0; rs2 = '0; rd = '0;
        rd_valid = '0; lat = '0; branch = '0; flush = 1'b0;
    endtask

    task automatic slot(input int i, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic dv, input logic [3:0] l,
                        input logic br);
        issue_valid[i] = 1'b1;
        rs1[i] = a; rs2[i] = b; rd[i] = d;
        rd_valid[i] = dv; lat[i] = l; branch[i] = br;
    endtask

    // Expectations are queued when the stimulus is applied and retired as the
    // DUT produces can_issue (before the edge) and its state outputs (after).
    task automatic step(input string tag, input logic [3:0] ca, input logic [3:0] cb,
                        input logic [31:0] ba, input logic [31:0] bb, input logic bs);
        can_exp_t ce;
        st_exp_t  se;
        can_q.push_back('{tag, ca, cb});
        st_q.push_back('{tag, ba, bb, bs});
        @(negedge clk);
        ce = can_q.pop_front();
        check({ce.tag, ".can"},    32'(can_a), 32'(ce.can_a));
        check({ce.tag, ".can_nb"}, 32'(can_b), 32'(ce.can_b));
        @(posedge clk);
        #1;
        se = st_q.pop_front();
        check({se.tag, ".busy"},    busy_a, se.busy_a);
        check({se.tag, ".busy_nb"}, busy_b, se.busy_b);
        check({se.tag, ".bstall"},  32'(bs_a), 32'(se.bs));
        check({se.tag, ".bstall_nb"}, 32'(bs_b), 32'(se.bs));
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",   busy_a, 32'h0);
        check("rst.bstall", 32'(bs_a), 32'h0);
        rst = 1'b0;

        step("empty", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);

        // Four independent single-cycle producers.
        clr();
        slot(0, 0, 0, 1, 1, 1, 0); slot(1, 0, 0, 2, 1, 1, 0);
        slot(2, 0, 0, 3, 1, 1, 0); slot(3, 0, 0, 4, 1, 1, 0);
        step("indep", 4'b1111, 4'b1111, 32'h1E, 32'h1E, 1'b0);
        clr();
        step("drain1", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);

        // x5 latency 3, then a reader of x5.
        slot(0, 0, 0, 5, 1, 3, 0);
        step("x5_prod", 4'b1111, 4'b1111, 32'h20, 32'h20, 1'b0);
        clr();
        slot(0, 5, 0, 0, 0, 0, 0);
        step("x5_t1", 4'b0000, 4'b0000, 32'h20, 32'h20, 1'b0);
        step("x5_t2", 4'b0000, 4'b0000, 32'h20, 32'h20, 1'b0);
        step("x5_t3", 4'b1111, 4'b0000, 32'h0, 32'h0, 1'b0);
        step("x5_t4", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);

        // Intra-bundle RAW on x7 blocks slot 2 and everything after it.
        clr();
        slot(0, 0, 0, 7, 1, 2, 0); slot(1, 0, 0, 8, 1, 2, 0);
        slot(2, 7, 0, 0, 0, 0, 0); slot(3, 0, 0, 10, 1, 1, 0);
        step("intra", 4'b0011, 4'b0011, 32'h180, 32'h180, 1'b0);
        clr();
        step("drain2a", 4'b1111, 4'b1111, 32'h180, 32'h180, 1'b0);
        step("drain2b", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);

        // Branch in slot 1 ends the bundle and opens a 2-cycle stall.
        slot(0, 0, 0, 11, 1, 1, 0); slot(1, 0, 0, 0, 0, 0, 1);
        slot(2, 0, 0, 12, 1, 1, 0); slot(3, 0, 0, 0, 0, 0, 0);
        step("br_fire", 4'b0011, 4'b0011, 32'h800, 32'h800, 1'b1);
        clr();
        slot(0, 0, 0, 13, 1, 0, 0);
        step("br_st1", 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1);
        step("br_st2", 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0);
        step("lat0", 4'b1111, 4'b1111, 32'h2000, 32'h2000, 1'b0);
        clr();
        step("drain3", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);

        // Flush with x9 busy (cnt 5) and the branch countdown at 2.
        slot(0, 0, 0, 9, 1, 5, 0); slot(1, 0, 0, 0, 0, 0, 1);
        step("x9_br", 4'b0011, 4'b0011, 32'h200, 32'h200, 1'b1);
        clr();
        slot(0, 9, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step("flush", 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        step("post_flush", 4'b1111, 4'b1111, 32'h0, 32'h0, 1'b0);
        clr();
        slot(0, 0, 0, 14, 1, 3, 0);
        flush = 1'b1;
        step("flush_drop", 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0);

        // x0 never tracked or blocking; x6 set up for WAW.
        clr();
        slot(0, 0, 0, 0, 1, 5, 0); slot(1, 0, 0, 0, 1, 2, 0);
        slot(2, 0, 0, 6, 1, 3, 0); slot(3, 0, 0, 0, 0, 0, 0);
        step("x0", 4'b1111, 4'b1111, 32'h40, 32'h40, 1'b0);
        clr();
        slot(0, 0, 0, 6, 1, 4, 0);
        step("waw_c3", 4'b0000, 4'b0000, 32'h40, 32'h40, 1'b0);
        step("waw_c2", 4'b0000, 4'b0000, 32'h40, 32'h40, 1'b0);
        // cnt 1: bypass instance reissues x6 (lat 4), the other lets it drain.
        step("waw_c1", 4'b1111, 4'b0000, 32'h40, 32'h0, 1'b0);
        clr();
        step("waw_tail", 4'b1111, 4'b1111, 32'h40, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
